// File: rtl/dco_tune_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dco_tune_ctrl_pkg
//  Description : Shared types and default constants for the DCO tuning
//                controller (FSM state encoding, default parameter values).
//  Revision    : 1.0  - initial release
// ============================================================================
package dco_tune_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAR    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int C_DEF_CODE_W   = 8;
    localparam int C_DEF_SETTLE   = 4;
    localparam int C_DEF_LOCK_CNT = 8;
    localparam int C_DEF_LOSS_CNT = 4;

endpackage
`default_nettype wire

// File: rtl/dco_tune_ctrl_settle.sv
`default_nettype none
// ============================================================================
//  Module      : dco_settle_timer
//  Description : Free-running modulo-SETTLE counter. strobe is high for one
//                cycle on the last cycle of every SETTLE-cycle hold window.
//                restart forces the window to begin again on the next edge.
//  Ports       : clk_ref  - clock
//                reset    - asynchronous active-high reset
//                restart  - synchronous restart of the hold window
//                strobe   - one-cycle sample strobe
//  Revision    : 1.0  - initial release
// ============================================================================
module dco_settle_timer
    import dco_tune_ctrl_pkg::*;
#(
    parameter int SETTLE = C_DEF_SETTLE
)(
    input  logic clk_ref,
    input  logic reset,
    input  logic restart,
    output logic strobe
);

    localparam int c_cnt_w = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SETTLE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign strobe = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dco_tune_ctrl
//  Description : DCO tuning controller. Binary (SAR) search of the control
//                code from the phase detector lead/lag result, followed by
//                +/-1 tracking and lock detection on direction alternation.
//  Ports       : clk_ref  - sole clock
//                reset    - asynchronous active-high reset
//                lead_lag - 1 = divided clock leads (DCO fast), 0 = lags
//                relock   - synchronous pulse restarting acquisition
//                dco_en   - DCO enable (registered)
//                dco_code - DCO control code, higher = faster (registered)
//                locked   - lock indication (registered)
//                code_sat - one-cycle flag: tracking step clipped (registered)
//  Config      : DCO_TUNE_LOSS_DETECT_EN - when defined, LOSS_CNT consecutive
//                same-direction steps in LOCKED drop lock back to TRACK.
//                When undefined, locked is sticky until reset/relock.
//  Revision    : 1.0  - initial release
// ============================================================================
module dco_tune_ctrl
    import dco_tune_ctrl_pkg::*;
#(
    parameter int CODE_W   = C_DEF_CODE_W,
    parameter int SETTLE   = C_DEF_SETTLE,
    parameter int LOCK_CNT = C_DEF_LOCK_CNT,
    parameter int LOSS_CNT = C_DEF_LOSS_CNT
)(
    input  logic              clk_ref,
    input  logic              reset,
    input  logic              lead_lag,
    input  logic              relock,
    output logic              dco_en,
    output logic [CODE_W-1:0] dco_code,
    output logic              locked,
    output logic              code_sat
);

    localparam int c_idx_w = (CODE_W > 2) ? $clog2(CODE_W) : 1;
    localparam int c_alt_w = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0]  c_code_max = '1;
    localparam logic [CODE_W-1:0]  c_code_msb = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(CODE_W - 1);
    localparam logic [c_alt_w-1:0] c_alt_lock = c_alt_w'(LOCK_CNT);

    state_t              r_state, w_state_n;
    logic [CODE_W-1:0]   r_code, w_code_n;
    logic                r_en, r_locked, w_locked_n, r_sat, w_sat_n;
    logic [c_alt_w-1:0]  r_alt, w_alt_n, w_alt_step;
    logic                r_prev_dn, w_prev_dn_n;
    logic                r_have_prev, w_have_prev_n;
    logic [c_idx_w-1:0]  r_idx, w_idx_n;
    logic                r_sar_start, w_sar_start_n;
    logic                w_restart, w_strobe, w_at_limit;
    logic [CODE_W-1:0]   w_step_code;

`ifdef DCO_TUNE_LOSS_DETECT_EN
    localparam int c_loss_w = $clog2(LOSS_CNT + 1);
    logic [c_loss_w-1:0] r_loss, w_loss_n, w_loss_inc;
`endif

    dco_settle_timer #(
        .SETTLE  (SETTLE)
    ) u_settle (
        .clk_ref (clk_ref),
        .reset   (reset),
        .restart (w_restart),
        .strobe  (w_strobe)
    );

    // lead_lag=1 means the DCO is fast, so the step is downwards.
    assign w_at_limit  = lead_lag ? (r_code == '0) : (r_code == c_code_max);
    assign w_step_code = lead_lag ? (r_code - CODE_W'(1)) : (r_code + CODE_W'(1));

    // Alternation run length; saturates at LOCK_CNT so it cannot wrap in LOCKED.
    always_comb begin
        w_alt_step = c_alt_w'(1);
        if (r_have_prev && (lead_lag != r_prev_dn)) begin
            w_alt_step = (r_alt == c_alt_lock) ? r_alt : (r_alt + c_alt_w'(1));
        end
    end

`ifdef DCO_TUNE_LOSS_DETECT_EN
    assign w_loss_inc = r_loss + c_loss_w'(1);
`endif

    always_comb begin
        w_state_n     = r_state;
        w_code_n      = r_code;
        w_locked_n    = r_locked;
        w_sat_n       = 1'b0;
        w_alt_n       = r_alt;
        w_prev_dn_n   = r_prev_dn;
        w_have_prev_n = r_have_prev;
        w_idx_n       = r_idx;
        w_sar_start_n = r_sar_start;
        w_restart     = 1'b0;
`ifdef DCO_TUNE_LOSS_DETECT_EN
        w_loss_n      = r_loss;
`endif
        if ((r_state != IDLE) && relock) begin
            // Relock lands in SAR with code 0; the MSB trial is applied on
            // the following cycle (r_sar_start) so the code is visibly cleared.
            w_state_n     = SAR;
            w_code_n      = '0;
            w_locked_n    = 1'b0;
            w_alt_n       = '0;
            w_have_prev_n = 1'b0;
            w_prev_dn_n   = 1'b0;
            w_idx_n       = c_idx_top;
            w_sar_start_n = 1'b1;
            w_restart     = 1'b1;
`ifdef DCO_TUNE_LOSS_DETECT_EN
            w_loss_n      = '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n     = SAR;
                    w_code_n      = c_code_msb;
                    w_idx_n       = c_idx_top;
                    w_sar_start_n = 1'b0;
                    w_restart     = 1'b1;
                end
                SAR: begin
                    if (r_sar_start) begin
                        w_code_n      = c_code_msb;
                        w_idx_n       = c_idx_top;
                        w_sar_start_n = 1'b0;
                        w_restart     = 1'b1;
                    end else if (w_strobe) begin
                        w_code_n[r_idx] = ~lead_lag;
                        if (r_idx == '0) begin
                            w_state_n     = TRACK;
                            w_alt_n       = '0;
                            w_have_prev_n = 1'b0;
                        end else begin
                            w_code_n[r_idx - c_idx_w'(1)] = 1'b1;
                            w_idx_n = r_idx - c_idx_w'(1);
                        end
                    end
                end
                TRACK, LOCKED: begin
                    if (w_strobe) begin
                        w_code_n      = w_at_limit ? r_code : w_step_code;
                        w_sat_n       = w_at_limit;
                        w_prev_dn_n   = lead_lag;
                        w_have_prev_n = 1'b1;
                        w_alt_n       = w_alt_step;
                        if ((r_state == TRACK) && (w_alt_step == c_alt_lock)) begin
                            w_state_n  = LOCKED;
                            w_locked_n = 1'b1;
`ifdef DCO_TUNE_LOSS_DETECT_EN
                            w_loss_n   = '0;
`endif
                        end
`ifdef DCO_TUNE_LOSS_DETECT_EN
                        if (r_state == LOCKED) begin
                            if (r_have_prev && (lead_lag == r_prev_dn)) begin
                                if (w_loss_inc == c_loss_w'(LOSS_CNT)) begin
                                    w_state_n  = TRACK;
                                    w_locked_n = 1'b0;
                                    w_alt_n    = c_alt_w'(1);
                                    w_loss_n   = '0;
                                end else begin
                                    w_loss_n   = w_loss_inc;
                                end
                            end else begin
                                w_loss_n = '0;
                            end
                        end
`endif
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_en        <= 1'b0;
            r_locked    <= 1'b0;
            r_sat       <= 1'b0;
            r_alt       <= '0;
            r_prev_dn   <= 1'b0;
            r_have_prev <= 1'b0;
            r_idx       <= '0;
            r_sar_start <= 1'b0;
`ifdef DCO_TUNE_LOSS_DETECT_EN
            r_loss      <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_code      <= w_code_n;
            r_en        <= (w_state_n != IDLE);
            r_locked    <= w_locked_n;
            r_sat       <= w_sat_n;
            r_alt       <= w_alt_n;
            r_prev_dn   <= w_prev_dn_n;
            r_have_prev <= w_have_prev_n;
            r_idx       <= w_idx_n;
            r_sar_start <= w_sar_start_n;
`ifdef DCO_TUNE_LOSS_DETECT_EN
            r_loss      <= w_loss_n;
`endif
        end
    end

    assign dco_en   = r_en;
    assign dco_code = r_code;
    assign locked   = r_locked;
    assign code_sat = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dco_tune_ctrl
//  Description : Self-checking bench for dco_tune_ctrl (CODE_W=8, SETTLE=4,
//                LOCK_CNT=8, LOSS_CNT=4). Phase detector model compares the
//                code against a threshold of 92, or forces lead_lag to 0/1.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_dco_tune_ctrl;

    logic       clk_ref;
    logic       reset;
    logic       lead_lag;
    logic       relock;
    logic       dco_en;
    logic [7:0] dco_code;
    logic       locked;
    logic       code_sat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = 0;   // 0: model (code > 92), 1: force 0, 2: force 1

    typedef struct {
        int         cyc;
        logic [7:0] code;
        logic       locked;
        logic       sat;
        logic       en;
    } vec_t;

    vec_t vecs [16];

    dco_tune_ctrl #(
        .CODE_W   (8),
        .SETTLE   (4),
        .LOCK_CNT (8),
        .LOSS_CNT (4)
    ) dut (
        .clk_ref  (clk_ref),
        .reset    (reset),
        .lead_lag (lead_lag),
        .relock   (relock),
        .dco_en   (dco_en),
        .dco_code (dco_code),
        .locked   (locked),
        .code_sat (code_sat)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic upd_lead();
        case (mode)
            0:       lead_lag = (dco_code > 8'd92);
            1:       lead_lag = 1'b0;
            default: lead_lag = 1'b1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
        cyc++;
        upd_lead();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string name, input logic [7:0] code, input logic lk,
                       input logic sat, input logic en);
        checks++;
        if (dco_code !== code || locked !== lk || code_sat !== sat || dco_en !== en) begin
            errors++;
            $display("FAIL %s cyc=%0d: got code=%0d locked=%b sat=%b en=%b, want code=%0d locked=%b sat=%b en=%b",
                     name, cyc, dco_code, locked, code_sat, dco_en, code, lk, sat, en);
        end
    endtask

    // Pulse reset, release just after an edge; the next edge is SAR entry (cyc 0).
    task automatic start_acq(input int m);
        mode  = m;
        reset = 1'b1;
        @(posedge clk_ref);
        #1;
        reset = 1'b0;
        cyc   = -1;
        upd_lead();
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        relock   = 1'b0;
        lead_lag = 1'b0;

        vecs[0]  = '{0,   8'd128, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3,   8'd128, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{4,   8'd64,  1'b0, 1'b0, 1'b1};
        vecs[3]  = '{8,   8'd96,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{12,  8'd80,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16,  8'd88,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{20,  8'd92,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{24,  8'd94,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{28,  8'd93,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{31,  8'd93,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{32,  8'd92,  1'b0, 1'b0, 1'b1};
        vecs[11] = '{35,  8'd92,  1'b0, 1'b0, 1'b1};
        vecs[12] = '{36,  8'd93,  1'b0, 1'b0, 1'b1};
        vecs[13] = '{63,  8'd93,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{64,  8'd92,  1'b1, 1'b0, 1'b1};
        vecs[15] = '{100, 8'd93,  1'b1, 1'b0, 1'b1};

        // Reset state
        @(posedge clk_ref);
        #1;
        chk("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);

        // Acquisition and tracking with the threshold model
        reset = 1'b0;
        cyc   = -1;
        mode  = 0;
        upd_lead();
        tick();
        for (int i = 0; i < 16; i++) begin
            run_to(vecs[i].cyc);
            chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].locked, vecs[i].sat, vecs[i].en);
        end

        // Relock coincident with the sample strobe that precedes edge 104
        run_to(103);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_clear", 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4 && dco_code != 8'd128; i++) tick();
        chk("relock_msb", 8'd128, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) tick();
        chk("relock_sar_done", 8'd92, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the bit-5 trial
        start_acq(0);
        run_to(9);
        chk("pre_reset_bit5", 8'd96, 1'b0, 1'b0, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_ref);
        #1;
        reset = 1'b0;
        cyc   = -1;
        upd_lead();
        chk("idle_after_release", 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sar_reentry", 8'd128, 1'b0, 1'b0, 1'b1);
        run_to(32);
        chk("sar_after_reset", 8'd92, 1'b0, 1'b0, 1'b1);

        // Saturation at the top of the range
        start_acq(1);
        run_to(32);
        chk("sar_max", 8'd255, 1'b0, 1'b0, 1'b1);
        run_to(35);
        chk("pre_sat_hi", 8'd255, 1'b0, 1'b0, 1'b1);
        run_to(36);
        chk("sat_hi", 8'd255, 1'b0, 1'b1, 1'b1);
        run_to(37);
        chk("sat_hi_clear", 8'd255, 1'b0, 1'b0, 1'b1);

        // Saturation at the bottom of the range
        start_acq(2);
        run_to(32);
        chk("sar_min", 8'd0, 1'b0, 1'b0, 1'b1);
        run_to(36);
        chk("sat_lo", 8'd0, 1'b0, 1'b1, 1'b1);

        // Lock, then persistent lead: loss detection (or sticky lock)
        start_acq(0);
        run_to(64);
        chk("lock_again", 8'd92, 1'b1, 1'b0, 1'b1);
        mode = 2;
        upd_lead();
        run_to(79);
        chk("loss_3_steps", 8'd89, 1'b1, 1'b0, 1'b1);
        run_to(80);
`ifdef DCO_TUNE_LOSS_DETECT_EN
        chk("loss_4_steps", 8'd88, 1'b0, 1'b0, 1'b1);
`else
        chk("sticky_lock", 8'd88, 1'b1, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dco_tune_ctrl.md
DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 8, meaning DCO control code width.
REQ-002 SHALL have parameter SETTLE, default 4, meaning clk_ref cycles each code is held before lead_lag is sampled (legal range 2..255).
REQ-003 SHALL have parameter LOCK_CNT, default 8, meaning consecutive direction alternations needed to declare lock.
REQ-004 SHALL have parameter LOSS_CNT, default 4, meaning consecutive same-direction steps that declare loss of lock.
REQ-005 SHALL have port clk_ref, input, 1 bit: sole clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port lead_lag, input, 1 bit: phase detector result; 1 = divided clock leads (DCO fast), 0 = lags.
REQ-008 SHALL have port relock, input, 1 bit: synchronous pulse that restarts acquisition.
REQ-009 SHALL have port dco_en, output, 1 bit: DCO enable.
REQ-010 SHALL have port dco_code, output, CODE_W bits: DCO control code; higher value = higher frequency.
REQ-011 SHALL have port locked, output, 1 bit: lock indication.
REQ-012 SHALL have port code_sat, output, 1 bit: tracking step was clipped at 0 or 2^CODE_W-1.

Function
REQ-013 SHALL implement FSM IDLE -> SAR -> TRACK -> LOCKED; all outputs registered.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then enter SAR with dco_en=1.
REQ-015 SAR SHALL resolve bits MSB to LSB: on entry to bit i, set bit i=1 and keep higher bits; hold SETTLE cycles; on the last held cycle, sample lead_lag; lead_lag=1 clears bit i, 0 keeps it.
REQ-016 SAR SHALL take exactly CODE_W*SETTLE cycles and then enter TRACK holding the resolved code.
REQ-017 TRACK/LOCKED SHALL sample lead_lag every SETTLE cycles; lead_lag=1 -> code-1, lead_lag=0 -> code+1.
REQ-018 Steps SHALL saturate at 0 and at 2^CODE_W-1; a clipped step SHALL set code_sat=1 for one cycle; code_sat SHALL be 0 otherwise.
REQ-019 The alternation counter SHALL increment when the step direction differs from the previous step and reset to 1 when it matches; the first TRACK step counts as 1.
REQ-020 When the alternation counter reaches LOCK_CNT, the FSM SHALL enter LOCKED and locked SHALL go 1 on the same edge.
REQ-021 relock=1 in any non-IDLE state SHALL enter SAR on the next edge with code=0, locked=0 and counters cleared; relock SHALL take priority over a coincident sample.
REQ-022 dco_en SHALL stay 1 in every state except IDLE.

Reset
REQ-023 reset SHALL asynchronously force IDLE, dco_code=0, dco_en=0, locked=0, code_sat=0 and clear all counters.
REQ-024 reset asserted mid-SAR or mid-TRACK SHALL discard all progress; acquisition SHALL restart from REQ-014.

Configuration
REQ-025 With DCO_TUNE_LOSS_DETECT_EN defined: in LOCKED, LOSS_CNT consecutive same-direction steps SHALL clear locked and return to TRACK with the alternation counter at 1.
REQ-026 Without DCO_TUNE_LOSS_DETECT_EN: locked SHALL be sticky until reset or relock; no loss counter SHALL be built.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, SAR, TRACK, LOCKED) and the default parameter constants.
REQ-028 The SETTLE hold counter SHALL be one sub-module, dco_settle_timer, producing a one-cycle sample strobe and restartable by the FSM.

Verification
REQ-029 Model: lead_lag = (dco_code > 92), CODE_W=8, SETTLE=4 -> dco_code=92 exactly 32 cycles after SAR entry.
REQ-030 Same model, continued -> code alternates 93/92; locked=1 on the 8th alternation; locked stays 1.
REQ-031 lead_lag held 0 -> SAR yields 255; next TRACK step gives code_sat=1 for one cycle and code stays 255.
REQ-032 relock pulse while LOCKED, coincident with a sample strobe -> next cycle SAR, code=0, locked=0, no step applied.
REQ-033 reset asserted mid-SAR at bit 5 -> outputs zero immediately (asynchronous); IDLE one cycle after release; SAR completes normally.
REQ-034 With DCO_TUNE_LOSS_DETECT_EN, lock, then force lead_lag=1 for 4 samples -> locked=0 after the 4th step, state TRACK; without the macro, locked stays 1.
